// File: rtl/sensor_acq_sequencer_if.sv
// Serial ADC link: the sequencer drives chip select, serial clock and channel,
// the ADC returns conversion data MSB first on adc_sdo.
interface sensor_acq_sequencer_if;
    logic       adc_cs_n;
    logic       adc_sclk;
    logic [1:0] adc_ch;
    logic       adc_sdo;

    modport master (
        output adc_cs_n,
        output adc_sclk,
        output adc_ch,
        input  adc_sdo
    );

    modport slave (
        input  adc_cs_n,
        input  adc_sclk,
        input  adc_ch,
        output adc_sdo
    );
endinterface

// File: rtl/sensor_acq_sequencer.sv
// Periodic three-channel ADC acquisition sequencer (temperature, light, power).
// Optional macro SENSOR_AVG_EN: two back-to-back conversions per channel, averaged.
module sensor_acq_sequencer #(
    parameter int SCLK_DIV      = 2,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          acq_en,
    sensor_acq_sequencer_if.master        adc,
    output logic [7:0]                    temperature_sensor,
    output logic [7:0]                    light_sensor,
    output logic [8:0]                    power_monitor,
    output logic                          sample_valid
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        SHIFT  = 3'd2,
        GAP    = 3'd3,
        UPDATE = 3'd4,
        WAIT   = 3'd5
    } state_t;

    localparam logic [7:0]  DIV_LAST    = 8'(SCLK_DIV - 1);
    localparam logic [15:0] PERIOD_LAST = 16'(SAMPLE_PERIOD - 1);
    localparam logic [15:0] CNT_MAX     = 16'hFFFF;
    localparam logic [3:0]  BIT_LAST    = 4'd12;
`ifdef SENSOR_AVG_EN
    localparam logic [2:0]  CONV_LAST   = 3'd5;
`else
    localparam logic [2:0]  CONV_LAST   = 3'd2;
`endif

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_conv;
    logic [2:0]  w_conv_next;
    logic [7:0]  r_div_cnt;
    logic [3:0]  r_bit_cnt;
    logic        r_gap_cnt;
    logic [15:0] r_frame_cnt;
    logic        r_sclk;
    logic        r_cs_n;
    logic [1:0]  r_ch;
    logic [9:0]  r_shift;
    logic [9:0]  r_shadow_temp;
    logic [9:0]  r_shadow_light;
    logic [9:0]  r_shadow_pwr;
    logic [7:0]  r_temp;
    logic [7:0]  r_light;
    logic [8:0]  r_pwr;
    logic        r_valid;

    logic        w_div_wrap;
    logic        w_rise;
    logic        w_fall;
    logic        w_conv_done;
    logic        w_frame_start;
    logic [1:0]  w_conv_ch;
    logic [1:0]  w_ch_next;
    logic [9:0]  w_code;
    logic        w_store;

    assign w_div_wrap  = (r_div_cnt == DIV_LAST);
    assign w_rise      = (r_state == SHIFT) && w_div_wrap && !r_sclk;
    assign w_fall      = (r_state == SHIFT) && w_div_wrap && r_sclk;
    assign w_conv_done = w_fall && (r_bit_cnt == BIT_LAST);

`ifdef SENSOR_AVG_EN
    assign w_conv_ch = r_conv[2:1];
    assign w_ch_next = w_conv_next[2:1];
`else
    assign w_conv_ch = r_conv[1:0];
    assign w_ch_next = w_conv_next[1:0];
`endif

    // Next-state and conversion-index decode
    always_comb begin
        w_state_next = r_state;
        w_conv_next  = r_conv;
        case (r_state)
            IDLE: begin
                if (acq_en) begin
                    w_state_next = START;
                    w_conv_next  = 3'd0;
                end else begin
                    w_state_next = IDLE;
                end
            end
            START: begin
                w_state_next = SHIFT;
            end
            SHIFT: begin
                if (w_conv_done) begin
                    w_state_next = GAP;
                end else begin
                    w_state_next = SHIFT;
                end
            end
            GAP: begin
                if (r_gap_cnt) begin
                    if (r_conv == CONV_LAST) begin
                        w_state_next = UPDATE;
                    end else begin
                        w_state_next = START;
                        w_conv_next  = r_conv + 3'd1;
                    end
                end else begin
                    w_state_next = GAP;
                end
            end
            UPDATE: begin
                w_state_next = WAIT;
            end
            WAIT: begin
                // A frame that overran the period leaves WAIT after a single cycle
                if (r_frame_cnt >= PERIOD_LAST) begin
                    if (acq_en) begin
                        w_state_next = START;
                        w_conv_next  = 3'd0;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_state_next = WAIT;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_conv_next  = 3'd0;
            end
        endcase
    end

    assign w_frame_start = (w_state_next == START) &&
                           ((r_state == IDLE) || (r_state == WAIT));

    // State and conversion-index registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_conv  <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_conv  <= w_conv_next;
        end
    end

    // Serial clock divider, bit counter and sclk generation (low phase first)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= 8'd0;
            r_bit_cnt <= 4'd0;
            r_sclk    <= 1'b0;
        end else begin
            if (r_state == SHIFT) begin
                r_div_cnt <= w_div_wrap ? 8'd0 : (r_div_cnt + 8'd1);
            end else begin
                r_div_cnt <= 8'd0;
            end
            if (r_state == START) begin
                r_bit_cnt <= 4'd0;
            end else if (w_rise) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end else begin
                r_bit_cnt <= r_bit_cnt;
            end
            if (w_state_next != SHIFT) begin
                r_sclk <= 1'b0;
            end else if (w_rise) begin
                r_sclk <= 1'b1;
            end else if (w_fall) begin
                r_sclk <= 1'b0;
            end else begin
                r_sclk <= r_sclk;
            end
        end
    end

    // Inter-conversion gap timer and frame period counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap_cnt   <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            r_gap_cnt <= (r_state == GAP) ? !r_gap_cnt : 1'b0;
            if (w_frame_start) begin
                r_frame_cnt <= 16'd0;
            end else if (r_frame_cnt != CNT_MAX) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end else begin
                r_frame_cnt <= r_frame_cnt;
            end
        end
    end

    // Chip select is low exactly in START and SHIFT; channel is latched on entry to START
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs_n <= 1'b1;
            r_ch   <= 2'd0;
        end else begin
            r_cs_n <= !((w_state_next == START) || (w_state_next == SHIFT));
            r_ch   <= (w_state_next == START) ? w_ch_next : r_ch;
        end
    end

    // Ten-bit shifter: the two leading bits of each conversion fall off the top
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= 10'd0;
        end else if (r_state == START) begin
            r_shift <= 10'd0;
        end else if (w_rise) begin
            r_shift <= {r_shift[8:0], adc.adc_sdo};
        end else begin
            r_shift <= r_shift;
        end
    end

`ifdef SENSOR_AVG_EN
    logic [9:0]  r_first;
    logic [10:0] w_sum;

    assign w_sum   = {1'b0, r_first} + {1'b0, r_shift};
    assign w_code  = w_sum[10:1];
    assign w_store = w_conv_done && r_conv[0];

    // First code of each back-to-back pair
    always_ff @(posedge clk) begin
        if (rst) begin
            r_first <= 10'd0;
        end else if (w_conv_done && !r_conv[0]) begin
            r_first <= r_shift;
        end else begin
            r_first <= r_first;
        end
    end
`else
    assign w_code  = r_shift;
    assign w_store = w_conv_done;
`endif

    // Per-channel shadow registers, written at the end of each channel's conversion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow_temp  <= 10'd0;
            r_shadow_light <= 10'd0;
            r_shadow_pwr   <= 10'd0;
        end else if (w_store) begin
            case (w_conv_ch)
                2'd0:    r_shadow_temp  <= w_code;
                2'd1:    r_shadow_light <= w_code;
                2'd2:    r_shadow_pwr   <= w_code;
                default: r_shadow_temp  <= r_shadow_temp;
            endcase
        end else begin
            r_shadow_temp  <= r_shadow_temp;
            r_shadow_light <= r_shadow_light;
            r_shadow_pwr   <= r_shadow_pwr;
        end
    end

    // Output readings load together with the sample_valid pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_temp  <= 8'd0;
            r_light <= 8'd0;
            r_pwr   <= 9'd0;
            r_valid <= 1'b0;
        end else if (w_state_next == UPDATE) begin
            r_temp  <= r_shadow_temp[9:2];
            r_light <= r_shadow_light[9:2];
            r_pwr   <= r_shadow_pwr[9:1];
            r_valid <= 1'b1;
        end else begin
            r_temp  <= r_temp;
            r_light <= r_light;
            r_pwr   <= r_pwr;
            r_valid <= 1'b0;
        end
    end

    assign adc.adc_cs_n        = r_cs_n;
    assign adc.adc_sclk        = r_sclk;
    assign adc.adc_ch          = r_ch;
    assign temperature_sensor  = r_temp;
    assign light_sensor        = r_light;
    assign power_monitor       = r_pwr;
    assign sample_valid        = r_valid;

endmodule

// File: tb/tb_sensor_acq_sequencer.sv
// Self-checking bench for sensor_acq_sequencer: ADC model, frame scoreboard,
// serial timing monitor and a second instance with a short sample period.
module tb_sensor_acq_sequencer;

    localparam int SCLK_DIV      = 2;
    localparam int SAMPLE_PERIOD = 1000;
    localparam int FAST_PERIOD   = 10;
`ifdef SENSOR_AVG_EN
    localparam int N_CONV = 6;
`else
    localparam int N_CONV = 3;
`endif
    localparam int FRAME_LEN = N_CONV * (3 + 24 * SCLK_DIV) + 1;

    typedef struct {
        logic [9:0] t;
        logic [9:0] l;
        logic [9:0] p;
        logic [7:0] exp_t;
        logic [7:0] exp_l;
        logic [8:0] exp_p;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       acq_en;
    logic [7:0] temperature_sensor, light_sensor;
    logic [8:0] power_monitor;
    logic       sample_valid;
    logic [7:0] f_temp, f_light;
    logic [8:0] f_pwr;
    logic       f_valid;

    sensor_acq_sequencer_if adc_if();
    sensor_acq_sequencer_if fast_if();

    sensor_acq_sequencer #(.SCLK_DIV(SCLK_DIV), .SAMPLE_PERIOD(SAMPLE_PERIOD)) u_dut (
        .clk(clk), .rst(rst), .acq_en(acq_en), .adc(adc_if),
        .temperature_sensor(temperature_sensor), .light_sensor(light_sensor),
        .power_monitor(power_monitor), .sample_valid(sample_valid)
    );

    sensor_acq_sequencer #(.SCLK_DIV(SCLK_DIV), .SAMPLE_PERIOD(FAST_PERIOD)) u_dut_fast (
        .clk(clk), .rst(rst), .acq_en(1'b1), .adc(fast_if),
        .temperature_sensor(f_temp), .light_sensor(f_light),
        .power_monitor(f_pwr), .sample_valid(f_valid)
    );

    assign fast_if.adc_sdo = 1'b0;

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    vec_t sb_q[$];
    vec_t vecs[5];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ADC model: codes per channel, two junk bits then the 10-bit code, MSB first
    logic [9:0]  m_code_t = 10'd0, m_code_t_b = 10'd0, m_code_l = 10'd0, m_code_p = 10'd0;
    logic [9:0]  m_code;
    logic [11:0] m_word = 12'd0;
    logic [1:0]  m_last_ch = 2'd3;
    logic        m_second = 1'b0;
    logic        m_in_win = 1'b0;
    logic        m_prev_sclk = 1'b0;
    int          m_rises = 0;

    always @(negedge clk) begin
        if (rst || adc_if.adc_cs_n) begin
            m_in_win    = 1'b0;
            m_rises     = 0;
            m_prev_sclk = 1'b0;
            adc_if.adc_sdo = 1'b0;
        end else begin
            if (!m_in_win) begin
                m_in_win  = 1'b1;
                m_second  = (adc_if.adc_ch == m_last_ch) && !m_second;
                m_last_ch = adc_if.adc_ch;
                case (adc_if.adc_ch)
                    2'd0:    m_code = m_second ? m_code_t_b : m_code_t;
                    2'd1:    m_code = m_code_l;
                    2'd2:    m_code = m_code_p;
                    default: m_code = 10'd0;
                endcase
                m_word = {2'b10, m_code};
            end
            if (adc_if.adc_sclk && !m_prev_sclk) m_rises++;
            m_prev_sclk = adc_if.adc_sclk;
            adc_if.adc_sdo = (m_rises < 12) ? m_word[11 - m_rises] : 1'b0;
        end
    end

    // Serial timing monitor and scoreboard for the main instance
    logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_valid = 1'b0, sp_known = 1'b0;
    int   hi_run = 0, win_cnt = 0, rises = 0, last_rise = -1, last_v = 0;
    int   cs_low_cnt = 0, n_valid = 0;
    vec_t e;

    always @(negedge clk) begin
        if (rst) begin
            prev_cs = 1'b1; prev_sclk = 1'b0; prev_valid = 1'b0; sp_known = 1'b0;
            hi_run = 0; win_cnt = 0; rises = 0; last_rise = -1;
        end else begin
            if (adc_if.adc_cs_n) check("sclk_idle", int'(adc_if.adc_sclk), 0);
            else cs_low_cnt++;
            if (prev_cs && !adc_if.adc_cs_n) begin
                if (win_cnt != 0) check("cs_gap", hi_run, 2);
                win_cnt++;
                rises = 0;
                last_rise = -1;
            end
            if (!prev_cs && adc_if.adc_cs_n) begin
                check("sclk_rises", rises, 12);
                hi_run = 0;
            end
            if (adc_if.adc_cs_n) hi_run++;
            if (adc_if.adc_sclk && !prev_sclk) begin
                rises++;
                if (last_rise >= 0) check("sclk_period", cyc - last_rise, 2 * SCLK_DIV);
                last_rise = cyc;
            end
            if (!adc_if.adc_sclk && prev_sclk) check("sclk_high", cyc - last_rise, SCLK_DIV);
            if (prev_valid) check("valid_width", int'(sample_valid), 0);
            if (sample_valid) begin
                n_valid++;
                check("conv_count", win_cnt, N_CONV);
                win_cnt = 0;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got pulse at cycle %0d, expected none", cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("temperature", int'(temperature_sensor), int'(e.exp_t));
                    check("light", int'(light_sensor), int'(e.exp_l));
                    check("power", int'(power_monitor), int'(e.exp_p));
                end
                if (sp_known && acq_en) check("valid_spacing", cyc - last_v, SAMPLE_PERIOD);
                last_v = cyc;
                sp_known = acq_en;
            end
            prev_cs = adc_if.adc_cs_n;
            prev_sclk = adc_if.adc_sclk;
            prev_valid = sample_valid;
        end
    end

    // Short-period instance: overrunning frames restart after one WAIT cycle
    logic f_known = 1'b0;
    int   f_last = 0;

    always @(negedge clk) begin
        if (rst) begin
            f_known = 1'b0;
        end else if (f_valid) begin
            if (f_known) check("fast_spacing", cyc - f_last, FRAME_LEN + 1);
            f_last = cyc;
            f_known = 1'b1;
        end
    end

    task automatic apply_codes(input vec_t v);
        m_code_t   = v.t;
        m_code_t_b = v.t;
        m_code_l   = v.l;
        m_code_p   = v.p;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int start;
        bit seen;
        start = n_valid;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_valid != start) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, int'(seen), 1);
    endtask

    task automatic wait_cs_ch(input string name, input logic [1:0] ch, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!adc_if.adc_cs_n && adc_if.adc_ch == ch) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, int'(seen), 1);
    endtask

    int snap;
    vec_t v;

    initial begin
        vecs[0] = '{10'h155, 10'h0CC, 10'h282, 8'h55, 8'h33, 9'h141};
        vecs[1] = '{10'h3FF, 10'h000, 10'h3FF, 8'hFF, 8'h00, 9'h1FF};
        vecs[2] = '{10'h000, 10'h3FF, 10'h001, 8'h00, 8'hFF, 9'h000};
        vecs[3] = '{10'h003, 10'h2A9, 10'h155, 8'h00, 8'hAA, 9'h0AA};
        vecs[4] = '{10'h204, 10'h17B, 10'h0FF, 8'h81, 8'h5E, 9'h07F};

        rst = 1'b1;
        acq_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", int'(adc_if.adc_cs_n), 1);
        check("rst_sclk", int'(adc_if.adc_sclk), 0);
        check("rst_ch", int'(adc_if.adc_ch), 0);
        check("rst_temp", int'(temperature_sensor), 0);
        check("rst_light", int'(light_sensor), 0);
        check("rst_power", int'(power_monitor), 0);
        check("rst_valid", int'(sample_valid), 0);
        rst = 1'b0;

        repeat (20) @(negedge clk);
        check("idle_cs_n", int'(adc_if.adc_cs_n), 1);
        check("idle_cs_low", cs_low_cnt, 0);

        for (int i = 0; i < 5; i++) begin
            apply_codes(vecs[i]);
            sb_q.push_back(vecs[i]);
            acq_en = 1'b1;
            wait_valid("frame_valid", 2500);
        end

        // acq_en dropped during the light conversion: frame finishes, then idle
        sb_q.push_back(vecs[4]);
        wait_cs_ch("wait_ch1", 2'd1, 1200);
        acq_en = 1'b0;
        wait_valid("drop_valid", 400);
        snap = cs_low_cnt;
        repeat (2500) @(negedge clk);
        check("drop_cs_low", cs_low_cnt - snap, 0);
        check("drop_cs_n", int'(adc_if.adc_cs_n), 1);

        // Reset during the power conversion aborts the frame and clears outputs
        apply_codes(vecs[1]);
        sb_q.push_back(vecs[1]);
        acq_en = 1'b1;
        wait_valid("restart_valid", 400);
        apply_codes(vecs[0]);
        wait_cs_ch("wait_ch2", 2'd2, 1200);
        rst = 1'b1;
        @(negedge clk);
        check("abort_cs_n", int'(adc_if.adc_cs_n), 1);
        check("abort_sclk", int'(adc_if.adc_sclk), 0);
        check("abort_temp", int'(temperature_sensor), 0);
        check("abort_light", int'(light_sensor), 0);
        check("abort_power", int'(power_monitor), 0);
        check("abort_valid", int'(sample_valid), 0);
        rst = 1'b0;
        apply_codes(vecs[2]);
        sb_q.push_back(vecs[2]);
        wait_valid("post_rst_valid", 400);

`ifdef SENSOR_AVG_EN
        v = '{10'h100, 10'h0CC, 10'h282, 8'h40, 8'h33, 9'h141};
        apply_codes(v);
        m_code_t_b = 10'h103;
        sb_q.push_back(v);
        wait_valid("avg_valid", 2500);
`endif

        repeat (5) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
